// File: rtl/adc_serial_responder.sv
// -----------------------------------------------------------------------------
// adc_serial_responder
//
// Target-side responder for a simple serial ADC protocol. While cs is low the
// initiator sends a start bit (din=1), then mode, ch1 and ch0. The responder
// samples the selected conversion source on the following edge, presents a
// null bit, shifts the 10-bit result out MSB first, then pulses done. Raising
// cs inside a frame aborts it and sets a sticky frame_err.
//
// Handshake: there is no valid/ready pair. cs low qualifies din on every
// rising clk edge; dout is meaningful whenever dout_en is high; done is a
// single-cycle pulse on the edge that completes a frame.
//
// Ports
//   clk        in   system and serial bit clock (one bit per period)
//   rstc       in   synchronous active-high reset
//   cs         in   active-low chip select
//   din        in   serial command bit
//   ain0..ain3 in   10-bit unsigned conversion sources
//   dout       out  registered serial result bit
//   dout_en    out  high while dout carries the null bit or a data bit
//   chan       out  channel captured by the most recent command
//   done       out  one-cycle pulse at frame completion
//   frame_err  out  sticky: cs rose mid-frame
//   state_dbg  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module adc_serial_responder (
   input  logic       clk,
   input  logic       rstc,
   input  logic       cs,
   input  logic       din,
   input  logic [9:0] ain0,
   input  logic [9:0] ain1,
   input  logic [9:0] ain2,
   input  logic [9:0] ain3,
   output logic       dout,
   output logic       dout_en,
   output logic [1:0] chan,
   output logic       done,
   output logic       frame_err,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CFG    = 3'd1,
      SAMPLE = 3'd2,
      NULLB  = 3'd3,
      DATA   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t     state, state_n;
   logic [1:0] cfg_cnt, cfg_cnt_n;   // which command bit CFG is capturing
   logic       mode_r, mode_n;
   logic       ch1_r, ch1_n;
   logic [1:0] chan_n;
   logic [9:0] shift_reg, shift_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic       dout_n, dout_en_n, done_n, frame_err_n;
   logic [9:0] result;
   logic [9:0] diff_a, diff_b;

   assign state_dbg = state;

   // Conversion result from the command captured in CFG. Differential mode
   // pairs (ain0,ain1) or (ain2,ain3) chosen by chan[1]; negative clamps to 0.
   always_comb begin
      diff_a = chan[1] ? ain2 : ain0;
      diff_b = chan[1] ? ain3 : ain1;
      result = '0;
      if (mode_r) begin
         case (chan)
            2'd0:    result = ain0;
            2'd1:    result = ain1;
            2'd2:    result = ain2;
            default: result = ain3;
         endcase
      end else if (diff_a >= diff_b) begin
         result = diff_a - diff_b;
      end
   end

   always_comb begin
      state_n     = state;
      cfg_cnt_n   = cfg_cnt;
      mode_n      = mode_r;
      ch1_n       = ch1_r;
      chan_n      = chan;
      shift_n     = shift_reg;
      bit_cnt_n   = bit_cnt;
      dout_n      = dout;
      dout_en_n   = dout_en;
      done_n      = 1'b0;
      frame_err_n = frame_err;

      case (state)
         IDLE: begin
            dout_n    = 1'b0;
            dout_en_n = 1'b0;
            // cs high takes priority over a coincident din=1
            if (!cs && din) begin
               state_n   = CFG;
               cfg_cnt_n = 2'd0;
            end
         end

         DONE: begin
            dout_n    = 1'b0;
            dout_en_n = 1'b0;
            if (cs) state_n = IDLE;
         end

         default: begin
            if (cs) begin
               // Abort of an active frame: no done pulse
               state_n     = IDLE;
               dout_n      = 1'b0;
               dout_en_n   = 1'b0;
               frame_err_n = 1'b1;
            end else begin
               case (state)
                  CFG: begin
                     cfg_cnt_n = cfg_cnt + 2'd1;
                     case (cfg_cnt)
                        2'd0:    mode_n = din;
                        2'd1:    ch1_n  = din;
                        default: begin
                           chan_n  = {ch1_r, din};
                           state_n = SAMPLE;
                        end
                     endcase
                  end
                  SAMPLE: begin
                     // Only point where ain is observed
                     shift_n   = result;
                     dout_n    = 1'b0;
                     dout_en_n = 1'b1;
                     state_n   = NULLB;
                  end
                  NULLB: begin
                     dout_n    = shift_reg[9];
                     shift_n   = {shift_reg[8:0], 1'b0};
                     bit_cnt_n = 4'd9;
                     state_n   = DATA;
                  end
                  DATA: begin
                     if (bit_cnt == 4'd0) begin
                        state_n   = DONE;
                        dout_n    = 1'b0;
                        dout_en_n = 1'b0;
                        done_n    = 1'b1;
                     end else begin
                        dout_n    = shift_reg[9];
                        shift_n   = {shift_reg[8:0], 1'b0};
                        bit_cnt_n = bit_cnt - 4'd1;
                     end
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstc) begin
         state     <= IDLE;
         cfg_cnt   <= 2'd0;
         mode_r    <= 1'b0;
         ch1_r     <= 1'b0;
         chan      <= 2'b00;
         shift_reg <= '0;
         bit_cnt   <= 4'd0;
         dout      <= 1'b0;
         dout_en   <= 1'b0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cfg_cnt   <= cfg_cnt_n;
         mode_r    <= mode_n;
         ch1_r     <= ch1_n;
         chan      <= chan_n;
         shift_reg <= shift_n;
         bit_cnt   <= bit_cnt_n;
         dout      <= dout_n;
         dout_en   <= dout_en_n;
         done      <= done_n;
         frame_err <= frame_err_n;
      end
   end

endmodule

// File: tb/tb_adc_serial_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_serial_responder
//
// Drives serial frames with randomized sources and filler bits, and compares
// every edge against a protocol-level model: the expected result is computed
// arithmetically from the command and the ain values present at the sample
// edge, expanded into an expected {done,dout_en,dout} queue.
// -----------------------------------------------------------------------------
module tb_adc_serial_responder;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rstc = 1'b1;
   logic       cs = 1'b1;
   logic       din = 1'b0;
   logic [9:0] ain0 = '0, ain1 = '0, ain2 = '0, ain3 = '0;
   logic       dout, dout_en, done, frame_err;
   logic [1:0] chan;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   adc_serial_responder dut (
      .clk(clk), .rstc(rstc), .cs(cs), .din(din),
      .ain0(ain0), .ain1(ain1), .ain2(ain2), .ain3(ain3),
      .dout(dout), .dout_en(dout_en), .chan(chan), .done(done),
      .frame_err(frame_err), .state_dbg(state_dbg)
   );

   // ---------------- model state / scoreboard ----------------
   int         vectors = 0;
   int         errors  = 0;
   int         cycle   = 0;
   int         done_cycle = -1;
   logic [9:0] fa [4];            // sources presented on the sample edge
   logic [1:0] exp_chan = 2'b00;
   logic       exp_ferr = 1'b0;
   logic [2:0] exp_q [$];         // expected {done,dout_en,dout} of data bits

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic rand_ain();
      ain0 = 10'($urandom_range(0, 1023));
      ain1 = 10'($urandom_range(0, 1023));
      ain2 = 10'($urandom_range(0, 1023));
      ain3 = 10'($urandom_range(0, 1023));
   endtask

   function automatic int ref_result(input logic mode, input logic [1:0] ch);
      int d;
      if (mode) return int'(fa[ch]);
      d = int'(fa[2 * ch[1]]) - int'(fa[2 * ch[1] + 1]);
      return (d < 0) ? 0 : d;
   endfunction

   // Idle-style edge: outputs must be quiet, chan/frame_err as modelled
   task automatic quiet_edge(input logic cs_v, input string tag);
      cs  = cs_v;
      din = 1'($urandom_range(0, 1));
      rand_ain();
      tick();
      vectors++;
      if ({done, dout_en, dout} !== 3'b000) begin
         errors++;
         $display("FAIL %s outs got=%b exp=000 t=%0t", tag, {done, dout_en, dout}, $time);
      end
      vectors++;
      if (chan !== exp_chan || frame_err !== exp_ferr) begin
         errors++;
         $display("FAIL %s chan/ferr got=%0d/%b exp=%0d/%b", tag, chan, frame_err, exp_chan, exp_ferr);
      end
   endtask

   // One frame: lead zeros, 16 protocol edges (abort/reset optional), then
   // hold in DONE for 'hold' edges and one cs-high edge back to IDLE.
   task automatic run_frame(input logic mode, input logic [1:0] ch, input int lead,
                            input int abort_at, input int reset_at, input int hold);
      logic [2:0] exp;
      logic [9:0] r10;
      bit         stopped = 0;
      for (int i = 0; i < lead; i++) begin
         cs = 1'b0; din = 1'b0; rand_ain();
         tick();
         vectors++;
         if ({done, dout_en, dout} !== 3'b000) begin
            errors++;
            $display("FAIL lead_zero outs got=%b exp=000", {done, dout_en, dout});
         end
      end
      r10 = 10'(ref_result(mode, ch));
      exp_q.delete();
      for (int e = 0; e < 16 && !stopped; e++) begin
         cs   = (e == abort_at);
         rstc = (e == reset_at);
         case (e)
            0:       din = 1'b1;
            1:       din = mode;
            2:       din = ch[1];
            3:       din = ch[0];
            default: din = 1'($urandom_range(0, 1));
         endcase
         if (e == 4) begin
            ain0 = fa[0]; ain1 = fa[1]; ain2 = fa[2]; ain3 = fa[3];
         end else begin
            rand_ain();
         end
         tick();
         if (rstc) begin
            exp_chan = 2'b00; exp_ferr = 1'b0; exp = 3'b000; stopped = 1;
         end else if (cs) begin
            exp_ferr = 1'b1; exp = 3'b000; stopped = 1;
         end else begin
            if (e == 3) exp_chan = ch;
            if (e < 4) exp = 3'b000;
            else if (e == 4) begin
               exp = 3'b010;
               for (int b = 9; b >= 0; b--) exp_q.push_back({2'b01, r10[b]});
            end else if (e < 15) exp = exp_q.pop_front();
            else begin
               exp = 3'b100;
               done_cycle = cycle;
            end
         end
         vectors++;
         if ({done, dout_en, dout} !== exp) begin
            errors++;
            $display("FAIL frame edge S+%0d {done,en,dout} got=%b exp=%b (mode=%b ch=%0d res=%0d)",
                     e, {done, dout_en, dout}, exp, mode, ch, r10);
         end
         vectors++;
         if (chan !== exp_chan || frame_err !== exp_ferr) begin
            errors++;
            $display("FAIL frame edge S+%0d chan/ferr got=%0d/%b exp=%0d/%b",
                     e, chan, frame_err, exp_chan, exp_ferr);
         end
      end
      rstc = 1'b0;
      if (!stopped) begin
         for (int h = 0; h < hold; h++) quiet_edge(1'b0, "done_hold");
      end
      quiet_edge(1'b1, "cs_high");
   endtask

   task automatic set_fa(input logic [9:0] a0, input logic [9:0] a1,
                         input logic [9:0] a2, input logic [9:0] a3);
      fa[0] = a0; fa[1] = a1; fa[2] = a2; fa[3] = a3;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstc = 1'b1; cs = 1'b0; din = 1'b1;
      tick(); tick();
      vectors++;
      if ({done, dout_en, dout, chan, frame_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset outs got=%b exp=000000", {done, dout_en, dout, chan, frame_err});
      end
      rstc = 1'b0;
      quiet_edge(1'b1, "post_reset");
   endtask

   task automatic test_frame();
      set_fa(10'h25A, 10'h3FF, 10'h000, 10'h155);
      run_frame(1'b1, 2'd0, 0, -1, -1, 2);
   endtask

   task automatic test_differential();
      set_fa(10'd7, 10'd9, 10'd100, 10'd340);
      run_frame(1'b0, 2'd2, 0, -1, -1, 1);
      set_fa(10'd7, 10'd9, 10'd340, 10'd100);
      run_frame(1'b0, 2'd2, 0, -1, -1, 1);
      set_fa(10'd500, 10'd499, 10'd0, 10'd0);
      run_frame(1'b0, 2'd1, 0, -1, -1, 0);
   endtask

   task automatic test_abort();
      set_fa(10'h2AA, 10'h111, 10'h222, 10'h333);
      run_frame(1'b1, 2'd1, 0, 9, -1, 0);
      run_frame(1'b1, 2'd3, 0, -1, -1, 1);
   endtask

   task automatic test_leading_zero();
      set_fa(10'h001, 10'h002, 10'h004, 10'h3C3);
      run_frame(1'b1, 2'd3, 3, -1, -1, 0);
   endtask

   task automatic test_reset_mid_frame();
      set_fa(10'h0F0, 10'h10F, 10'h3E1, 10'h21E);
      run_frame(1'b1, 2'd2, 0, -1, 10, 0);
      run_frame(1'b1, 2'd2, 1, -1, -1, 0);
   endtask

   task automatic test_cs_priority();
      cs = 1'b1; din = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         cs = 1'b0; din = 1'b0; rand_ain();
         tick();
         vectors++;
         if ({done, dout_en, dout} !== 3'b000) begin
            errors++;
            $display("FAIL cs_priority outs got=%b exp=000 at %0d", {done, dout_en, dout}, i);
         end
      end
      quiet_edge(1'b1, "cs_priority_end");
   endtask

   task automatic test_back_to_back();
      int first;
      set_fa(10'h123, 10'h234, 10'h345, 10'h056);
      run_frame(1'b1, 2'd1, 0, -1, -1, 0);
      first = done_cycle;
      run_frame(1'b0, 2'd0, 0, -1, -1, 0);
      vectors++;
      if (done_cycle - first !== 17) begin
         errors++;
         $display("FAIL back_to_back done spacing got=%0d exp=17", done_cycle - first);
      end
   endtask

   task automatic test_random();
      int ab, rs;
      for (int n = 0; n < 30; n++) begin
         set_fa(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
         rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
         run_frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), ab, rs, int'($urandom_range(0, 2)));
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_frame();
      test_differential();
      test_abort();
      test_leading_zero();
      test_reset_mid_frame();
      test_cs_priority();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
